// File: rtl/display_processor_pkg.sv
// Shared types for the memory stage: access sizes, bus FSM states, writeback select.
// Also holds the alignment rule used by the optional misalignment trap.
package display_processor_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } mem_state_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    return ((size == MEM_HALF) && off[0]) || ((size == MEM_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane steering for the data bus: store strobes/replicated write data and
// load lane extraction with sign/zero extension. Purely combinational.
module load_store_align
  import display_processor_pkg::*;
(
  input  logic [1:0]  i_off,
  input  mem_size_t   i_size,
  input  logic        i_store,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Half accesses only look at off[1]: an odd half offset is truncated to its container.
  always_comb begin
    o_wstrb = 4'h0;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      MEM_BYTE: begin
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      MEM_HALF: begin
        o_wstrb = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        o_wstrb = 4'hF;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
    if (!i_store) o_wstrb = 4'h0;
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline M stage: E->M register, data-bus request/response FSM and stall generation.
// Optional MEM_MISALIGN_TRAP_EN adds m_misaligned and suppresses misaligned bus accesses.
//
// state | meaning
// IDLE  | no access outstanding; M holds a non-memory op, a bubble or a trapped access
// REQ   | address phase, dbus_req_valid high until dbus_req_ready
// RESP  | load accepted, waiting for dbus_rvalid
module memory_stage
  import display_processor_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] e_alu_result,
  input  logic [DATA_W-1:0] e_write_data,
  input  logic [4:0]        e_rd,
  input  logic [DATA_W-1:0] e_pc_plus_4,
  input  logic              e_reg_write,
  input  result_src_t       e_result_src,
  input  logic              e_mem_read,
  input  logic              e_mem_write,
  input  mem_size_t         e_mem_size,
  input  logic              e_mem_unsigned,
  output logic [DATA_W-1:0] m_alu_result,
  output logic [4:0]        m_rd,
  output logic              m_reg_write,
  output logic              m_wb_valid,
  output result_src_t       m_result_src,
  output logic [DATA_W-1:0] m_pc_plus_4,
  output logic [DATA_W-1:0] m_read_data,
  output logic              m_mem_busy,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic [DATA_W-1:0] dbus_addr,
  output logic              dbus_we,
  output logic [3:0]        dbus_wstrb,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              m_misaligned
`endif
);

  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_write_data;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_pc_plus_4;
  logic              r_reg_write;
  result_src_t       r_result_src;
  logic              r_mem_read;
  logic              r_mem_write;
  mem_size_t         r_mem_size;
  logic              r_mem_unsigned;
  logic              r_misaligned;
  mem_state_t        r_state;

  mem_state_t        w_state_next;
  logic              w_busy;
  logic              w_e_mem;
  logic              w_e_misaligned;
  logic [DATA_W-1:0] w_load_data;

  assign w_e_mem = e_mem_read | e_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_e_misaligned = w_e_mem && is_misaligned(e_mem_size, e_alu_result[1:0]);
  assign m_misaligned   = r_misaligned;
`else
  assign w_e_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_result   <= '0;
      r_write_data   <= '0;
      r_rd           <= '0;
      r_pc_plus_4    <= '0;
      r_reg_write    <= 1'b0;
      r_result_src   <= RES_ALU;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_size     <= MEM_BYTE;
      r_mem_unsigned <= 1'b0;
      r_misaligned   <= 1'b0;
    end else if (!w_busy) begin
      r_alu_result   <= e_alu_result;
      r_write_data   <= e_write_data;
      r_rd           <= e_rd;
      r_pc_plus_4    <= e_pc_plus_4;
      r_reg_write    <= e_reg_write;
      r_result_src   <= e_result_src;
      r_mem_read     <= e_mem_read;
      r_mem_write    <= e_mem_write;
      r_mem_size     <= e_mem_size;
      r_mem_unsigned <= e_mem_unsigned;
      r_misaligned   <= w_e_misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // The completion cycle is not busy, so the next op is captured on the same edge
  // and its first state overrides the local transition.
  always_comb begin
    w_state_next   = r_state;
    w_busy         = 1'b0;
    dbus_req_valid = 1'b0;
    m_read_data    = '0;
    case (r_state)
      IDLE: ;
      REQ: begin
        dbus_req_valid = 1'b1;
        w_busy         = !(dbus_req_ready && r_mem_write);
        if (dbus_req_ready) w_state_next = r_mem_write ? IDLE : RESP;
      end
      RESP: begin
        if (dbus_rvalid) begin
          w_state_next = IDLE;
          m_read_data  = w_load_data;
        end else begin
          w_busy = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (!w_busy) w_state_next = (w_e_mem && !w_e_misaligned) ? REQ : IDLE;
  end

  load_store_align u_align (
    .i_off      (r_alu_result[1:0]),
    .i_size     (r_mem_size),
    .i_store    (r_mem_write),
    .i_unsigned (r_mem_unsigned),
    .i_wdata    (r_write_data),
    .i_rdata    (dbus_rdata),
    .o_wstrb    (dbus_wstrb),
    .o_wdata    (dbus_wdata),
    .o_rdata    (w_load_data)
  );

  assign dbus_addr    = {r_alu_result[DATA_W-1:2], 2'b00};
  assign dbus_we      = r_mem_write;
  assign m_mem_busy   = w_busy;
  assign m_wb_valid   = !w_busy && !r_misaligned;
  assign m_alu_result = r_alu_result;
  assign m_rd         = r_rd;
  assign m_reg_write  = r_reg_write;
  assign m_result_src = r_result_src;
  assign m_pc_plus_4  = r_pc_plus_4;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: table of ops run back-to-back through a scoreboard queue,
// a bus responder with per-op latencies, and a hand-written reset-in-RESP sequence.
module tb_memory_stage;
  import display_processor_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] e_alu_result, e_write_data, e_pc_plus_4;
  logic [4:0]  e_rd;
  logic        e_reg_write, e_mem_read, e_mem_write, e_mem_unsigned;
  result_src_t e_result_src;
  mem_size_t   e_mem_size;
  logic [31:0] m_alu_result, m_pc_plus_4, m_read_data;
  logic [4:0]  m_rd;
  logic        m_reg_write, m_wb_valid, m_mem_busy;
  result_src_t m_result_src;
  logic        dbus_req_valid, dbus_req_ready, dbus_we, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wstrb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        m_misaligned;
`endif

  memory_stage dut (
    .clk            (clk),
    .reset          (reset),
    .e_alu_result   (e_alu_result),
    .e_write_data   (e_write_data),
    .e_rd           (e_rd),
    .e_pc_plus_4    (e_pc_plus_4),
    .e_reg_write    (e_reg_write),
    .e_result_src   (e_result_src),
    .e_mem_read     (e_mem_read),
    .e_mem_write    (e_mem_write),
    .e_mem_size     (e_mem_size),
    .e_mem_unsigned (e_mem_unsigned),
    .m_alu_result   (m_alu_result),
    .m_rd           (m_rd),
    .m_reg_write    (m_reg_write),
    .m_wb_valid     (m_wb_valid),
    .m_result_src   (m_result_src),
    .m_pc_plus_4    (m_pc_plus_4),
    .m_read_data    (m_read_data),
    .m_mem_busy     (m_mem_busy),
    .dbus_req_valid (dbus_req_valid),
    .dbus_req_ready (dbus_req_ready),
    .dbus_addr      (dbus_addr),
    .dbus_we        (dbus_we),
    .dbus_wstrb     (dbus_wstrb),
    .dbus_wdata     (dbus_wdata),
    .dbus_rvalid    (dbus_rvalid),
    .dbus_rdata     (dbus_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .m_misaligned   (m_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    result_src_t src;
    logic        rw, rd_en, wr_en, uns, noise, mis_cand;
    mem_size_t   size;
    logic [31:0] rdata;
    int          rdly, vdly;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                              input result_src_t src, input logic rw, input logic rd_en,
                              input logic wr_en, input mem_size_t size, input logic uns,
                              input logic [31:0] rdata, input int rdly, input int vdly,
                              input logic noise, input logic [31:0] eaddr, input logic [3:0] estrb,
                              input logic [31:0] ewdata, input logic [31:0] erdata,
                              input logic mis_cand);
    vec_t v;
    v.alu = alu; v.wd = wd; v.pc4 = alu + 32'd4; v.rd = rd; v.src = src; v.rw = rw;
    v.rd_en = rd_en; v.wr_en = wr_en; v.size = size; v.uns = uns; v.rdata = rdata;
    v.rdly = rdly; v.vdly = vdly; v.noise = noise; v.exp_addr = eaddr; v.exp_strb = estrb;
    v.exp_wdata = ewdata; v.exp_rdata = erdata; v.mis_cand = mis_cand;
    return v;
  endfunction

  function automatic vec_t bubble();
    vec_t v;
    v = mk(32'h0, 32'h0, 5'd0, RES_ALU, 1'b0, 1'b0, 1'b0, MEM_BYTE, 1'b0, 32'h0, 0, 0, 1'b0,
           32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    v.pc4 = 32'h0;
    return v;
  endfunction

  task automatic drive_e(input vec_t v);
    e_alu_result   = v.alu;
    e_write_data   = v.wd;
    e_rd           = v.rd;
    e_pc_plus_4    = v.pc4;
    e_reg_write    = v.rw;
    e_result_src   = v.src;
    e_mem_read     = v.rd_en;
    e_mem_write    = v.wr_en;
    e_mem_size     = v.size;
    e_mem_unsigned = v.uns;
  endtask

  // Drives v into E, then services the bus for whatever sits in M until M completes.
  task automatic run_op(input vec_t v);
    vec_t m;
    int   rcnt, vcnt, reqs, exp_lat;
    bit   acc, done, mis, mem;
    @(negedge clk);
    drive_e(v);
    sb.push_back(v);
    m    = sb[0];
    mis  = TRAP_BUILD && m.mis_cand;
    mem  = m.rd_en || m.wr_en;
    rcnt = 0; vcnt = 0; reqs = 0; acc = 1'b0; done = 1'b0;
    if (!mem || mis)  exp_lat = 1;
    else if (m.wr_en) exp_lat = m.rdly + 1;
    else              exp_lat = m.rdly + m.vdly + 2;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      dbus_req_ready = dbus_req_valid && (rcnt == m.rdly);
      dbus_rvalid    = (acc && (vcnt == m.vdly)) || (m.noise && dbus_req_valid);
      dbus_rdata     = !dbus_rvalid ? 32'hA5A5A5A5 : (acc ? m.rdata : 32'hFFFFFFFF);
      #1;
      if (dbus_req_valid) begin
        chk("req_addr", dbus_addr, m.exp_addr);
        chk("req_we", {31'b0, dbus_we}, {31'b0, m.wr_en});
        chk("req_wstrb", {28'b0, dbus_wstrb}, {28'b0, m.exp_strb});
        if (m.wr_en) chk("req_wdata", dbus_wdata, m.exp_wdata);
      end
      if (dbus_req_valid && dbus_req_ready) reqs++;
      if (!m_mem_busy) begin
        done = 1'b1;
        chk("m_alu_result", m_alu_result, m.alu);
        chk("m_rd", {27'b0, m_rd}, {27'b0, m.rd});
        chk("m_reg_write", {31'b0, m_reg_write}, {31'b0, m.rw});
        chk("m_result_src", 32'(m_result_src), 32'(m.src));
        chk("m_pc_plus_4", m_pc_plus_4, m.pc4);
        chk("m_read_data", m_read_data, (m.rd_en && !mis) ? m.exp_rdata : 32'h0);
        chk("latency", 32'(cyc + 1), 32'(exp_lat));
        chk("req_count", 32'(reqs), (mem && !mis) ? 32'd1 : 32'd0);
        chk("m_wb_valid", {31'b0, m_wb_valid}, {31'b0, !mis});
`ifdef MEM_MISALIGN_TRAP_EN
        chk("m_misaligned", {31'b0, m_misaligned}, {31'b0, mis});
`endif
        void'(sb.pop_front());
      end else begin
        chk("read_data_gated", m_read_data, 32'h0);
        chk("wb_valid_busy", {31'b0, m_wb_valid}, 32'h0);
      end
      if (acc) vcnt++;
      if (dbus_req_valid && dbus_req_ready) acc = 1'b1;
      else if (dbus_req_valid) rcnt++;
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $display("FAIL op_timeout: M never completed, expected completion within 40 cycles");
      void'(sb.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1;
    dbus_req_ready = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata = 32'h0;
    drive_e(bubble());

    // alu, wd, rd, src, rw, rd_en, wr_en, size, uns, rdata, rdly, vdly, noise, addr, strb, wdata, rdata_exp, mis_cand
    tbl.push_back(mk(32'h0000_1234, 32'h0, 5'd5, RES_ALU, 1, 0, 0, MEM_BYTE, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(32'h0000_0103, 32'h0000_00AB, 5'd0, RES_ALU, 0, 0, 1, MEM_BYTE, 0, 32'h0, 3, 0, 0, 32'h100, 4'b1000, 32'hABABABAB, 32'h0, 0));
    tbl.push_back(mk(32'h0000_0202, 32'h0, 5'd7, RES_MEM, 1, 1, 0, MEM_HALF, 0, 32'h8001_0000, 0, 1, 0, 32'h200, 4'h0, 32'h0, 32'hFFFF8001, 0));
    tbl.push_back(mk(32'h0000_0202, 32'h0, 5'd8, RES_MEM, 1, 1, 0, MEM_HALF, 1, 32'h8001_0000, 0, 1, 0, 32'h200, 4'h0, 32'h0, 32'h00008001, 0));
    tbl.push_back(mk(32'h0000_0401, 32'h0, 5'd9, RES_MEM, 1, 1, 0, MEM_BYTE, 0, 32'h1122_9F44, 1, 0, 1, 32'h400, 4'h0, 32'h0, 32'hFFFFFF9F, 0));
    tbl.push_back(mk(32'h0000_0403, 32'h0, 5'd10, RES_MEM, 1, 1, 0, MEM_BYTE, 1, 32'hC500_0000, 0, 2, 1, 32'h400, 4'h0, 32'h0, 32'h000000C5, 0));
    tbl.push_back(mk(32'h0000_0410, 32'h0, 5'd11, RES_MEM, 1, 1, 0, MEM_BYTE, 0, 32'h0000_007F, 0, 0, 0, 32'h410, 4'h0, 32'h0, 32'h0000007F, 0));
    tbl.push_back(mk(32'h0000_0420, 32'h0, 5'd12, RES_MEM, 1, 1, 0, MEM_HALF, 0, 32'h0000_F00F, 0, 0, 0, 32'h420, 4'h0, 32'h0, 32'hFFFFF00F, 0));
    tbl.push_back(mk(32'h0000_0500, 32'h0, 5'd13, RES_MEM, 1, 1, 0, MEM_WORD, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'h500, 4'h0, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(32'h0000_0704, 32'h89AB_CDEF, 5'd0, RES_ALU, 0, 0, 1, MEM_WORD, 0, 32'h0, 0, 0, 0, 32'h704, 4'hF, 32'h89ABCDEF, 32'h0, 0));
    tbl.push_back(mk(32'h0000_0602, 32'h1234_CAFE, 5'd0, RES_ALU, 0, 0, 1, MEM_HALF, 0, 32'h0, 1, 0, 0, 32'h600, 4'b1100, 32'hCAFECAFE, 32'h0, 0));
    tbl.push_back(mk(32'h0000_0800, 32'h0, 5'd14, RES_MEM, 1, 1, 0, MEM_WORD, 0, 32'h0BAD_F00D, 0, 0, 0, 32'h800, 4'h0, 32'h0, 32'h0BADF00D, 0));
    tbl.push_back(mk(32'h0000_0800, 32'h0000_005A, 5'd0, RES_ALU, 0, 0, 1, MEM_BYTE, 0, 32'h0, 0, 0, 0, 32'h800, 4'b0001, 32'h5A5A5A5A, 32'h0, 0));
    tbl.push_back(mk(32'h0000_0301, 32'h0, 5'd15, RES_MEM, 1, 1, 0, MEM_WORD, 0, 32'h1357_2468, 0, 0, 0, 32'h300, 4'h0, 32'h0, 32'h13572468, 1));
    tbl.push_back(mk(32'h0000_0203, 32'h0, 5'd16, RES_MEM, 1, 1, 0, MEM_HALF, 0, 32'h7FFF_1234, 0, 0, 0, 32'h200, 4'h0, 32'h0, 32'h00007FFF, 1));
    tbl.push_back(mk(32'h0000_0601, 32'h0000_BEEF, 5'd0, RES_ALU, 0, 0, 1, MEM_HALF, 0, 32'h0, 0, 0, 0, 32'h600, 4'b0011, 32'hBEEFBEEF, 32'h0, 1));
    tbl.push_back(mk(32'hFFFF_FFF0, 32'h0, 5'd1, RES_PC4, 1, 0, 0, MEM_BYTE, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0));
    tbl.push_back(bubble());

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, dbus_req_valid}, 32'h0);
    chk("rst_busy", {31'b0, m_mem_busy}, 32'h0);
    chk("rst_alu_result", m_alu_result, 32'h0);
    chk("rst_read_data", m_read_data, 32'h0);

    sb.push_back(bubble());
    foreach (tbl[i]) run_op(tbl[i]);

    // Reset while a load waits in RESP; a late rvalid must be ignored.
    @(negedge clk);
    drive_e(tbl[8]);
    dbus_req_ready = 1'b0;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    drive_e(bubble());
    dbus_req_ready = 1'b1;
    #1;
    chk("mid_req_valid", {31'b0, dbus_req_valid}, 32'h1);
    @(negedge clk);
    dbus_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_resp_busy", {31'b0, m_mem_busy}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'h1234_5678;
    #1;
    chk("post_rst_busy", {31'b0, m_mem_busy}, 32'h0);
    chk("post_rst_req_valid", {31'b0, dbus_req_valid}, 32'h0);
    chk("post_rst_read_data", m_read_data, 32'h0);
    chk("post_rst_alu_result", m_alu_result, 32'h0);
    chk("post_rst_rd", {27'b0, m_rd}, 32'h0);
    @(negedge clk);
    dbus_rvalid = 1'b0;
    #1;
    chk("post_rst_busy2", {31'b0, m_mem_busy}, 32'h0);
    chk("post_rst_req_valid2", {31'b0, dbus_req_valid}, 32'h0);
    chk("post_rst_wb_valid", {31'b0, m_wb_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline M stage: directly downstream of the execute stage, upstream of writeback.
- Registers the E-stage outputs and drives the data-bus request (valid/ready address phase, separate read-response phase).
- Generates byte strobes, aligns and extends load data, and stalls the pipeline through m_mem_busy while a bus access is outstanding.

Parameters:
- DATA_W, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- e_alu_result  in  32  effective address, or result for non-memory ops
- e_write_data  in  32  store data (forwarded rs2)
- e_rd  in  5  destination register
- e_pc_plus_4  in  32  link value
- e_reg_write  in  1  instruction writes rd
- e_result_src  in  result_src_t  writeback mux select
- e_mem_read  in  1  load
- e_mem_write  in  1  store
- e_mem_size  in  mem_size_t  MEM_BYTE / MEM_HALF / MEM_WORD
- e_mem_unsigned  in  1  zero-extend the load
- m_alu_result  out  32  registered; forwarding source
- m_rd  out  5  registered
- m_reg_write  out  1  registered; hazard-unit view
- m_wb_valid  out  1  equals !m_mem_busy; writeback captures a bubble when low
- m_result_src  out  result_src_t  registered
- m_pc_plus_4  out  32  registered
- m_read_data  out  32  aligned, extended load data; valid in the completion cycle
- m_mem_busy  out  1  to hazard unit; stalls F/D/E and holds M
- dbus_req_valid  out  1  request valid
- dbus_req_ready  in  1  request accepted
- dbus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dbus_we  out  1  write request
- dbus_wstrb  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_rvalid  in  1  read response valid
- dbus_rdata  in  32  read response data

Behaviour:
- Pipeline register: captures all e_* inputs at each posedge where !m_mem_busy; holds while busy.
- Reset: register cleared to 0; all registered outputs are 0; state IDLE; dbus_req_valid=0; m_mem_busy=0.
- FSM states: IDLE, REQ, RESP.
  - On capture, next state = REQ if the incoming op has mem_read or mem_write, else IDLE.
  - REQ: dbus_req_valid=1. On ready with a store -> IDLE (completion). On ready with a load -> RESP.
  - RESP: on dbus_rvalid -> IDLE (completion).
  - dbus_rvalid is ignored in IDLE and REQ. A response is never accepted in the same cycle as its request.
- m_mem_busy (combinational):
  - (REQ && !(ready && store)) || (RESP && !rvalid).
  - The completion cycle is not busy, so the next instruction is captured at the same edge.
- Minimum latency: non-memory op and store 1 cycle in M; load 2 cycles.
- Request signals are held stable while valid && !ready.
- Address offset off = addr[1:0].
  - Byte: wstrb = 4'b0001<<off; wdata = {4{wd[7:0]}}.
  - Half: wstrb = 4'b0011<<{off[1],1'b0}; wdata = {2{wd[15:0]}}.
  - Word: wstrb = 4'hF; wdata = wd.
  - Loads: dbus_we=0, wstrb=4'h0.
- Load data: lane = rdata >> (8*off) (half uses off[1]*16). Sign-extend unless m_mem_unsigned; word is passed through.
- m_read_data = 0 outside the load completion cycle.
- Reset mid-access: immediately abandons the access (valid drops, state IDLE). A late rvalid after reset is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- With the macro: half with off[0]=1, or word with off!=0, is misaligned.
  - No bus request is issued; state stays IDLE.
  - Adds output m_misaligned (1 bit), high for that instruction's M cycle.
  - m_wb_valid is forced 0 for that instruction.
- Without the macro: no port is added. Low address bits are truncated to the natural container (half uses off&2, word ignores off) and the access proceeds.

Decomposition:
- display_processor_pkg gains:
  - mem_size_t (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10)
  - mem_state_t (IDLE, REQ, RESP)
  - result_src_t, if not already present
- Sub-module LoadStoreAlign: pure combinational wstrb/wdata generation and load extract/extend. The FSM and register stay in memory_stage.

Test Plan:
- ALU op: e_alu_result=0x1234, reg_write=1 -> m_alu_result=0x1234 next cycle; busy never asserted; dbus_req_valid=0.
- Store byte: addr 0x103, wd=0xAB, ready held low 3 cycles -> valid, addr 0x100, wstrb 4'b1000, wdata 0xABABABAB stable all 4 cycles; busy 3 cycles; M advances on the ready cycle.
- Signed load half: addr 0x202, rdata=0x8001_0000, rvalid 2 cycles after accept -> m_read_data=0xFFFF8001 in the completion cycle only; unsigned variant gives 0x00008001.
- Back-to-back load, then store, with ready=1 and immediate rvalid -> load 2 cycles, store 1 cycle; no request dropped or duplicated.
- Reset asserted in RESP, then rvalid pulses -> outputs 0, state IDLE, busy 0, response ignored.
- MEM_MISALIGN_TRAP_EN: word load at 0x301 -> no dbus_req_valid, m_misaligned=1 for 1 cycle, m_wb_valid=0. Without the macro -> addr 0x300, normal load.
